approx_ha_array_pipe: RTL and testbench



---
 rtl/approx_ha_array_pipe.sv | 171 +++++++++++++++++
 tb/tb_approx_ha_array_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/approx_ha_array_pipe.sv
// Pipelined half-adder-array partial-product stage with runtime per-column approximation.
// Optional residual-error output enabled by defining APPROX_HA_ERR_EN.

module approx_ha_group #(
    parameter int WIDTH = 8,
    parameter int CUTW  = 5,
    parameter int BASE  = 0
) (
    input  logic [1:0]       x2,
    input  logic [WIDTH-1:0] y,
    input  logic [CUTW-1:0]  cut_lo,
    input  logic [CUTW-1:0]  cut_hi,
    output logic [WIDTH-2:0] b,
    output logic [WIDTH:0]   t
`ifdef APPROX_HA_ERR_EN
    ,
    output logic [WIDTH:0]   err
`endif
);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_r;

    assign w_a = y & {WIDTH{x2[0]}};
    assign w_r = y & {WIDTH{x2[1]}};

    // cut_hi arrives already clamped to >= cut_lo
    always_comb begin
        b = '0;
        t = '0;
`ifdef APPROX_HA_ERR_EN
        err = '0;
`endif
        t[0] = w_a[0];
        for (int k = 1; k < WIDTH; k++) begin
            if (CUTW'(BASE + k) >= cut_hi) begin
                t[k] = w_a[k] ^ w_r[k-1];
                if (k == WIDTH - 1) t[WIDTH] = w_a[k] & w_r[k-1];
                else                b[k-1]   = w_a[k] & w_r[k-1];
            end else if (CUTW'(BASE + k) >= cut_lo) begin
                t[k] = w_a[k] | w_r[k-1];
`ifdef APPROX_HA_ERR_EN
                err = err + ((WIDTH+1)'(w_a[k] & w_r[k-1]) << k);
`endif
            end else begin
`ifdef APPROX_HA_ERR_EN
                err = err + (((WIDTH+1)'(w_a[k]) + (WIDTH+1)'(w_r[k-1])) << k);
`endif
            end
        end
        b[WIDTH-2] = w_r[WIDTH-1];
    end
endmodule

module approx_ha_array_pipe #(
    parameter int WIDTH = 8,
    parameter int CUTW  = $clog2(2*WIDTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [WIDTH-1:0]                   x,
    input  logic [WIDTH-1:0]                   y,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               cfg_we,
    input  logic [CUTW-1:0]                    cfg_cut_lo,
    input  logic [CUTW-1:0]                    cfg_cut_hi,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [(WIDTH/2)*(WIDTH-1)-1:0]     ha_b,
    output logic [(WIDTH/2)*(WIDTH+1)-1:0]     ha_t
`ifdef APPROX_HA_ERR_EN
    ,
    output logic [2*WIDTH-1:0]                 err
`endif
);
    localparam int G  = WIDTH / 2;
    localparam int BW = G * (WIDTH - 1);
    localparam int TW = G * (WIDTH + 1);

    logic [CUTW-1:0]  r_cut_lo, r_cut_hi;
    logic             r_s1_valid, r_s2_valid;
    logic [WIDTH-1:0] r_x, r_y;
    logic [CUTW-1:0]  r_lo, r_hi;
    logic [BW-1:0]    r_b;
    logic [TW-1:0]    r_t;

    logic             w_s1_adv, w_s2_adv;
    logic [CUTW-1:0]  w_hi;
    logic [BW-1:0]    w_b;
    logic [TW-1:0]    w_t;

    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign ha_b      = r_b;
    assign ha_t      = r_t;
    assign w_hi      = (r_hi < r_lo) ? r_lo : r_hi;

`ifdef APPROX_HA_ERR_EN
    logic [G-1:0][WIDTH:0] w_gerr;
    logic [2*WIDTH-1:0]    w_err;
    logic [2*WIDTH-1:0]    r_err;

    assign err = r_err;

    always_comb begin
        w_err = '0;
        for (int g = 0; g < G; g++)
            w_err = w_err + ((2*WIDTH)'(w_gerr[g]) << (2*g));
    end
`endif

    for (genvar g = 0; g < G; g++) begin : g_grp
        approx_ha_group #(.WIDTH(WIDTH), .CUTW(CUTW), .BASE(2*g)) u_grp (
            .x2     (r_x[2*g +: 2]),
            .y      (r_y),
            .cut_lo (r_lo),
            .cut_hi (w_hi),
            .b      (w_b[g*(WIDTH-1) +: WIDTH-1]),
            .t      (w_t[g*(WIDTH+1) +: WIDTH+1])
`ifdef APPROX_HA_ERR_EN
            ,
            .err    (w_gerr[g])
`endif
        );
    end

    // S1 snapshots the cuts as they were before any same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cut_lo   <= '0;
            r_cut_hi   <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_lo       <= '0;
            r_hi       <= '0;
            r_b        <= '0;
            r_t        <= '0;
`ifdef APPROX_HA_ERR_EN
            r_err      <= '0;
`endif
        end else begin
            if (cfg_we) begin
                r_cut_lo <= cfg_cut_lo;
                r_cut_hi <= cfg_cut_hi;
            end
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_x  <= x;
                    r_y  <= y;
                    r_lo <= r_cut_lo;
                    r_hi <= r_cut_hi;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_b <= w_b;
                    r_t <= w_t;
`ifdef APPROX_HA_ERR_EN
                    r_err <= w_err;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_approx_ha_array_pipe.sv
// Directed bench for approx_ha_array_pipe (WIDTH=8): exactness, cut modes, stall, cut snapshot, reset.
module tb_approx_ha_array_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  x, y;
    logic        in_valid, in_ready;
    logic        cfg_we;
    logic [4:0]  cfg_cut_lo, cfg_cut_hi;
    logic        out_valid, out_ready;
    logic [27:0] ha_b;
    logic [35:0] ha_t;
`ifdef APPROX_HA_ERR_EN
    logic [15:0] err;
`endif

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    approx_ha_array_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (x),
        .y          (y),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cfg_we     (cfg_we),
        .cfg_cut_lo (cfg_cut_lo),
        .cfg_cut_hi (cfg_cut_hi),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ha_b       (ha_b),
        .ha_t       (ha_t)
`ifdef APPROX_HA_ERR_EN
        ,
        .err        (err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] recon(input logic [27:0] hb, input logic [35:0] ht);
        logic [31:0] s;
        s = '0;
        for (int g = 0; g < 4; g++) begin
            for (int i = 0; i < 9; i++) s = s + (32'(ht[g*9+i]) << (2*g+i));
            for (int i = 0; i < 7; i++) s = s + (32'(hb[g*7+i]) << (2*g+i+2));
        end
        return s;
    endfunction

    task automatic set_cuts(input logic [4:0] lo, input logic [4:0] hi);
        cfg_cut_lo = lo;
        cfg_cut_hi = hi;
        cfg_we     = 1'b1;
        @(posedge clk); #1;
        cfg_we     = 1'b0;
    endtask

    // Single transaction with out_ready high; checks 2-cycle latency, leaves result on the outputs
    task automatic run1(input logic [7:0] a, input logic [7:0] b, output logic [31:0] r);
        x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat1", out_valid, 0);
        @(posedge clk); #1;
        chk("lat2", out_valid, 1);
        r = recon(ha_b, ha_t);
    endtask

    logic [7:0]  tx [6] = '{8'd10, 8'd15, 8'd255, 8'd100, 8'd7, 8'd128};
    logic [7:0]  ty [6] = '{8'd20, 8'd15, 8'd2,   8'd100, 8'd9, 8'd128};
    logic [31:0] te [6] = '{32'd200, 32'd225, 32'd510, 32'd10000, 32'd63, 32'd16384};

    initial begin
        logic [31:0] r;
        int ii, oi, c;
        logic saw_nr;

        rst_n = 1'b0; x = '0; y = '0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_cut_lo = '0; cfg_cut_hi = '0;
        #12;
        chk("rst_ov", out_valid, 0);
        chk("rst_ir", in_ready, 1);
        chk("rst_t", ha_t, 0);
        chk("rst_b", ha_b, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fully exact
        run1(8'd255, 8'd255, r); chk("ex_ff", r, 65025);
`ifdef APPROX_HA_ERR_EN
        chk("ex_err", err, 0);
`endif
        run1(8'hA5, 8'h3C, r); chk("ex_a5", r, 9900);
        run1(8'd1, 8'd128, r); chk("ex_1", r, 128);
        run1(8'd200, 8'd7, r); chk("ex_200", r, 1400);

        // OR on weight 1
        set_cuts(5'd0, 5'd2);
        run1(8'd3, 8'd3, r); chk("or_rec", r, 7);
        chk("or_t", ha_t[2:0], 3'b111);
        chk("or_b0", ha_b[0], 0);
`ifdef APPROX_HA_ERR_EN
        chk("or_err", err, 2);
`endif

        // cut_hi < cut_lo: weight 1 eliminated, no OR region
        set_cuts(5'd2, 5'd0);
        run1(8'd3, 8'd3, r); chk("inv_rec", r, 5);

        // everything eliminated, only fixed bits left
        set_cuts(5'd16, 5'd16);
        run1(8'd255, 8'd255, r); chk("el_rec", r, 21845);
        chk("el_t", ha_t, {4{9'h001}});
        chk("el_b", ha_b, {4{7'h40}});
`ifdef APPROX_HA_ERR_EN
        chk("el_err", err, 43180);
`endif

        // back-to-back stream with a 3-cycle stall
        set_cuts(5'd0, 5'd0);
        @(posedge clk); #1;
        ii = 0; oi = 0; c = 0; saw_nr = 1'b0;
        in_valid = 1'b1; x = tx[0]; y = ty[0]; out_ready = 1'b1;
        while (oi < 6 && c < 100) begin
            @(negedge clk);
            if (!in_ready) saw_nr = 1'b1;
            if (out_valid) begin
                chk("strm", recon(ha_b, ha_t), te[oi]);
                if (out_ready) oi++;
            end
            if (in_valid && in_ready) ii++;
            @(posedge clk); #1;
            c++;
            in_valid = (ii < 6);
            if (ii < 6) begin x = tx[ii]; y = ty[ii]; end
            out_ready = !(c >= 3 && c <= 5);
        end
        chk("strm_cnt", oi, 6);
        chk("strm_nr", saw_nr, 1);
        chk("strm_idle", out_valid, 0);

        // cut write right after accepting A must not affect A
        out_ready = 1'b1;
        x = 8'd255; y = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_cut_lo = 5'd4; cfg_cut_hi = 5'd6; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("snapA_v", out_valid, 1);
        chk("snapA", recon(ha_b, ha_t), 65025);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("snapB_v", out_valid, 1);
        chk("snapB", recon(ha_b, ha_t), 64853);
`ifdef APPROX_HA_ERR_EN
        chk("snapB_err", err, 172);
`endif

        // reset with two transactions in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        x = 8'd3; y = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        x = 8'd5; y = 8'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fl_ov", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_ov", out_valid, 0);
        chk("ar_ir", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_ov1", out_valid, 0);
        @(posedge clk); #1;
        chk("post_ov2", out_valid, 0);
        run1(8'd255, 8'd255, r); chk("post_cut", r, 65025);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
